// File: rtl/demux_pkg.sv
// demux_pkg: shared types and constants for the registered 1-to-3 demultiplexer.
//   DEFAULT_WORD_LENGTH : default data width of the input and all destinations.
//   dest_e              : resolved destination of the incoming word.
//   slot_state_e        : per-destination holding slot state (EMPTY/FULL).
//   DROP_COUNT_MAX      : saturation value of the optional drop counter.
//   resolve_dest()      : one-hot select to dest_e, priority first > second > third.
package demux_pkg;

    localparam int DEFAULT_WORD_LENGTH = 32;
    localparam logic [7:0] DROP_COUNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        DEST_NONE,
        DEST_FIRST,
        DEST_SECOND,
        DEST_THIRD
    } dest_e;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_e;

    function automatic dest_e resolve_dest(input logic sel_first,
                                           input logic sel_second,
                                           input logic sel_third);
        if (sel_first) begin
            return DEST_FIRST;
        end else if (sel_second) begin
            return DEST_SECOND;
        end else if (sel_third) begin
            return DEST_THIRD;
        end
        return DEST_NONE;
    endfunction

endpackage

// File: rtl/demux_1_to_3_reg_out_slot.sv
// out_slot: one-entry holding register for a single demux destination.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset.
//   load          : accept of an incoming word to this destination (this cycle).
//   load_data     : word to capture on load.
//   ready         : downstream consumer takes the held word this cycle.
//   can_load      : slot can take a word this cycle (EMPTY, or FULL and draining).
//   data          : held word; keeps its last value after it has been drained.
//   valid         : slot holds an undelivered word.
//   state         : slot state, exposed for observation.
module out_slot
    import demux_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [WORD_LENGTH-1:0] load_data,
    input  logic                   ready,
    output logic                   can_load,
    output logic [WORD_LENGTH-1:0] data,
    output logic                   valid,
    output slot_state_e            state
);

    slot_state_e            state_q, state_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;

    // A FULL slot whose consumer takes the word this cycle frees up at the same
    // edge, so it can be refilled without a bubble.
    assign can_load = (state_q == SLOT_EMPTY) || ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = load_data;
        end else if ((state_q == SLOT_FULL) && ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign data  = data_q;
    assign valid = (state_q == SLOT_FULL);
    assign state = state_q;

endmodule

// File: rtl/demux_1_to_3_reg.sv
// demux_1_to_3_reg: registered 1-to-3 demultiplexer. One word per cycle is
// routed to one of three single-entry destination slots picked by one-hot
// selects (priority first > second > third).
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset.
//   in_data, in_valid, in_ready     : input word handshake.
//   sel_first/second/third          : destination selects.
//   first/second/third              : destination data (registered).
//   first/second/third_valid        : destination holds an undelivered word.
//   first/second/third_ready        : destination consumer takes the word.
//   drop_count                      : saturating dropped-word count, only
//                                     when DEMUX_DROP_COUNT_EN is defined.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid, once raised, holds with stable data until that transfer. Words
// with no select are always accepted (in_ready=1) and discarded.
module demux_1_to_3_reg
    import demux_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WORD_LENGTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sel_first,
    input  logic                   sel_second,
    input  logic                   sel_third,
    output logic [WORD_LENGTH-1:0] first,
    output logic                   first_valid,
    input  logic                   first_ready,
    output logic [WORD_LENGTH-1:0] second,
    output logic                   second_valid,
    input  logic                   second_ready,
`ifdef DEMUX_DROP_COUNT_EN
    output logic [7:0]             drop_count,
`endif
    output logic [WORD_LENGTH-1:0] third,
    output logic                   third_valid,
    input  logic                   third_ready
);

    dest_e       dest;
    logic        accept;
    logic        first_can_load, second_can_load, third_can_load;
    slot_state_e first_state, second_state, third_state;

    assign dest = resolve_dest(sel_first, sel_second, sel_third);

    always_comb begin
        in_ready = 1'b1;
        case (dest)
            DEST_FIRST:  in_ready = first_can_load;
            DEST_SECOND: in_ready = second_can_load;
            DEST_THIRD:  in_ready = third_can_load;
            default:     in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready;

    out_slot #(.WORD_LENGTH(WORD_LENGTH)) u_first_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept && (dest == DEST_FIRST)),
        .load_data (in_data),
        .ready     (first_ready),
        .can_load  (first_can_load),
        .data      (first),
        .valid     (first_valid),
        .state     (first_state)
    );

    out_slot #(.WORD_LENGTH(WORD_LENGTH)) u_second_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept && (dest == DEST_SECOND)),
        .load_data (in_data),
        .ready     (second_ready),
        .can_load  (second_can_load),
        .data      (second),
        .valid     (second_valid),
        .state     (second_state)
    );

    out_slot #(.WORD_LENGTH(WORD_LENGTH)) u_third_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept && (dest == DEST_THIRD)),
        .load_data (in_data),
        .ready     (third_ready),
        .can_load  (third_can_load),
        .data      (third),
        .valid     (third_valid),
        .state     (third_state)
    );

`ifdef DEMUX_DROP_COUNT_EN
    logic [7:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (in_valid && (dest == DEST_NONE) && (drop_count_q != DROP_COUNT_MAX)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule
